// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-fetch and execute handshake bundle
// between the PC sequencer and the memory/decoder/datapath side.
interface pc_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              fetchReq;
    logic [ADDR_W-1:0] fetchAddr;
    logic              fetchAck;
    logic              decodeStrobe;
    logic              execStart;
    logic              execDone;
    logic              jumpSignal;
    logic [2:0]        IR;
    logic [ADDR_W-1:0] Address;
    logic              halt;

    modport master (
        output fetchReq,
        output fetchAddr,
        output decodeStrobe,
        output execStart,
        input  fetchAck,
        input  execDone,
        input  jumpSignal,
        input  IR,
        input  Address,
        input  halt
    );

    modport slave (
        input  fetchReq,
        input  fetchAddr,
        input  decodeStrobe,
        input  execStart,
        output fetchAck,
        output execDone,
        output jumpSignal,
        output IR,
        output Address,
        output halt
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns PC and ZF/CF, steps FETCH/DECODE/EXECUTE/UPDATE
// and resolves conditional jumps against the registered flags.
module pc_sequencer #(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.master    bus,
    input  logic              flagWe,
    input  logic              aluZF,
    input  logic              aluCF,
    output logic              ZF,
    output logic              CF,
    output logic [ADDR_W-1:0] PC,
    output logic              jumpTaken,
    output logic              halted
);
    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        UPDATE,
        HALTED
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pcInc;
    logic              zfNext;
    logic              cfNext;
    logic [7:0]        condVec;
    logic              take;

    assign bus.fetchAddr = PC;

    // Jump decision uses the flags as they will stand in UPDATE,
    // so a flag write in the execDone cycle is already folded in.
    always_comb begin
        pcInc   = PC + ADDR_W'(1);
        zfNext  = flagWe ? aluZF : ZF;
        cfNext  = flagWe ? aluCF : CF;
        condVec = {2'b00, zfNext | cfNext, ~cfNext,
                   cfNext, ~zfNext, zfNext, 1'b1};
        take    = bus.jumpSignal & condVec[bus.IR];
    end

    // Sequencer FSM with registered handshake outputs, flags and PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FETCH;
            PC               <= RESET_PC;
            target           <= '0;
            ZF               <= 1'b0;
            CF               <= 1'b0;
            bus.fetchReq     <= 1'b0;
            bus.decodeStrobe <= 1'b0;
            bus.execStart    <= 1'b0;
            jumpTaken        <= 1'b0;
            halted           <= 1'b0;
        end else begin
            if (flagWe && state != HALTED) begin
                ZF <= aluZF;
                CF <= aluCF;
            end
            unique case (state)
                FETCH: begin
                    if (bus.fetchReq && bus.fetchAck) begin
                        bus.fetchReq     <= 1'b0;
                        bus.decodeStrobe <= 1'b1;
                        state            <= DECODE;
                    end else begin
                        bus.fetchReq <= 1'b1;
                    end
                end
                DECODE: begin
                    bus.decodeStrobe <= 1'b0;
                    bus.execStart    <= 1'b1;
                    state            <= EXECUTE;
                end
                EXECUTE: begin
                    bus.execStart <= 1'b0;
                    if (bus.execDone) begin
                        target <= bus.Address;
                        if (bus.halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            jumpTaken <= take;
                            state     <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    PC           <= jumpTaken ? target : pcInc;
                    jumpTaken    <= 1'b0;
                    bus.fetchReq <= 1'b1;
                    state        <= FETCH;
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed checks of pc_sequencer
// against an instruction-level reference model.
module tb_pc_sequencer;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flagWe = 1'b0;
    logic          aluZF = 1'b0;
    logic          aluCF = 1'b0;
    logic          ZF;
    logic          CF;
    logic [AW-1:0] PC;
    logic          jumpTaken;
    logic          halted;

    int total = 0;
    int bad = 0;
    int cycCnt = 0;

    logic [AW-1:0] mPc = '0;
    bit            mZF = 1'b0;
    bit            mCF = 1'b0;

    pc_sequencer_if #(.ADDR_W(AW)) bus();

    pc_sequencer #(.ADDR_W(AW), .RESET_PC(11'd0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .flagWe(flagWe),
        .aluZF(aluZF),
        .aluCF(aluCF),
        .ZF(ZF),
        .CF(CF),
        .PC(PC),
        .jumpTaken(jumpTaken),
        .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycCnt <= cycCnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Condition table written straight from the jump-code rules.
    function automatic bit condHolds(input logic [2:0] ir, input bit z, input bit c);
        case (ir)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return c;
            3'd4: return !c;
            3'd5: return z || c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mPc = '0;
        mZF = 1'b0;
        mCF = 1'b0;
    endtask

    task automatic modelStep(input bit jmp, input logic [2:0] ir,
                             input logic [AW-1:0] addr, input bit fwe,
                             input bit zf, input bit cf, output bit expJt);
        if (fwe) begin
            mZF = zf;
            mCF = cf;
        end
        expJt = jmp && condHolds(ir, mZF, mCF);
        mPc = expJt ? addr : mPc + 11'd1;
    endtask

    // Drives one instruction through the handshakes; reports what it saw.
    task automatic doInstr(input bit jmp, input logic [2:0] ir,
                           input logic [AW-1:0] addr, input bit hlt,
                           input int fdly, input int edly, input bit fwe,
                           input bit zf, input bit cf,
                           output bit jt, output int cyc, output bit ok);
        int n;
        int c0;
        logic [AW-1:0] a0;
        ok = 1'b1;
        jt = 1'b0;
        n = 0;
        while (bus.fetchReq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) ok = 1'b0;
        c0 = cycCnt;
        a0 = bus.fetchAddr;
        for (int i = 0; i < fdly; i++) begin
            bus.execDone = 1'($urandom);
            bus.halt = 1'($urandom);
            @(negedge clk);
            if (bus.fetchReq !== 1'b1 || bus.fetchAddr !== a0
                || bus.decodeStrobe !== 1'b0) ok = 1'b0;
        end
        bus.execDone = 1'b0;
        bus.halt = 1'b0;
        bus.fetchAck = 1'b1;
        @(negedge clk);
        bus.fetchAck = 1'b0;
        if (bus.decodeStrobe !== 1'b1 || bus.fetchReq !== 1'b0) ok = 1'b0;
        @(negedge clk);
        if (bus.execStart !== 1'b1 || bus.decodeStrobe !== 1'b0) ok = 1'b0;
        for (int i = 0; i < edly; i++) begin
            bus.jumpSignal = 1'($urandom);
            bus.IR = 3'($urandom);
            bus.Address = AW'($urandom);
            bus.halt = 1'($urandom);
            bus.fetchAck = 1'($urandom);
            @(negedge clk);
            if (bus.execStart !== 1'b0) ok = 1'b0;
        end
        bus.fetchAck = 1'b0;
        bus.execDone = 1'b1;
        bus.jumpSignal = jmp;
        bus.IR = ir;
        bus.Address = addr;
        bus.halt = hlt;
        flagWe = fwe;
        aluZF = zf;
        aluCF = cf;
        @(negedge clk);
        bus.execDone = 1'b0;
        bus.halt = 1'b0;
        bus.jumpSignal = 1'b0;
        flagWe = 1'b0;
        jt = jumpTaken;
        if (!hlt) begin
            @(negedge clk);
            if (jumpTaken !== 1'b0) ok = 1'b0;
        end
        cyc = cycCnt - c0;
    endtask

    task automatic runInstr(input bit jmp, input logic [2:0] ir,
                            input logic [AW-1:0] addr, input int fdly,
                            input int edly, input bit fwe, input bit zf,
                            input bit cf, output bit expJt, output bit jt,
                            output int cyc, output bit ok);
        modelStep(jmp, ir, addr, fwe, zf, cf, expJt);
        doInstr(jmp, ir, addr, 1'b0, fdly, edly, fwe, zf, cf, jt, cyc, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({PC, ZF, CF, bus.fetchReq, bus.decodeStrobe, bus.execStart,
             jumpTaken, halted} !== {11'd0, 7'd0}) begin
            bad++;
            $display("FAIL reset_state: got PC=%0d ZF=%b CF=%b req=%b ds=%b es=%b jt=%b h=%b want all 0",
                     PC, ZF, CF, bus.fetchReq, bus.decodeStrobe,
                     bus.execStart, jumpTaken, halted);
        end
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        total++;
        if (bus.fetchReq !== 1'b1 || bus.fetchAddr !== 11'd0) begin
            bad++;
            $display("FAIL reset_fetch: got req=%b addr=%0d want req=1 addr=0",
                     bus.fetchReq, bus.fetchAddr);
        end
    endtask

    task automatic test_sequential();
        bit e, j, ok;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            runInstr(1'b0, 3'd0, 11'd0, 0, 0, 1'b0, 1'b0, 1'b0, e, j, cyc, ok);
            total++;
            if (PC !== mPc || j !== 1'b0) begin
                bad++;
                $display("FAIL seq_pc[%0d]: got PC=%0d jt=%b want PC=%0d jt=0",
                         i, PC, j, mPc);
            end
            total++;
            if (cyc != 4 || !ok) begin
                bad++;
                $display("FAIL seq_timing[%0d]: got cycles=%0d ok=%b want 4 ok=1",
                         i, cyc, ok);
            end
        end
    endtask

    task automatic test_jump_zf();
        bit e, j, ok;
        int cyc;
        runInstr(1'b1, 3'b001, 11'd6, 0, 0, 1'b1, 1'b1, 1'b0, e, j, cyc, ok);
        total++;
        if (PC !== 11'd6 || j !== 1'b1 || ZF !== 1'b1 || !ok) begin
            bad++;
            $display("FAIL jump_zf: got PC=%0d jt=%b ZF=%b ok=%b want PC=6 jt=1 ZF=1 ok=1",
                     PC, j, ZF, ok);
        end
        runInstr(1'b1, 3'b010, 11'd100, 0, 1, 1'b0, 1'b0, 1'b0, e, j, cyc, ok);
        total++;
        if (PC !== 11'd7 || j !== 1'b0 || !ok) begin
            bad++;
            $display("FAIL jump_nzf: got PC=%0d jt=%b ok=%b want PC=7 jt=0 ok=1",
                     PC, j, ok);
        end
    endtask

    task automatic test_cond_cf();
        bit e, j, ok;
        int cyc;
        logic [2:0] irs [5] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        runInstr(1'b0, 3'd0, 11'd0, 0, 0, 1'b1, 1'b0, 1'b1, e, j, cyc, ok);
        for (int i = 0; i < 5; i++) begin
            runInstr(1'b1, irs[i], AW'($urandom_range(0, 2047)), 0, 0,
                     1'b0, 1'b0, 1'b0, e, j, cyc, ok);
            total++;
            if (PC !== mPc || j !== e || !ok) begin
                bad++;
                $display("FAIL cond_cf IR=%b: got PC=%0d jt=%b ok=%b want PC=%0d jt=%b",
                         irs[i], PC, j, ok, mPc, e);
            end
        end
    endtask

    task automatic test_wrap_stall();
        bit e, j, ok;
        int cyc;
        runInstr(1'b1, 3'b000, 11'd2047, 0, 0, 1'b0, 1'b0, 1'b0, e, j, cyc, ok);
        total++;
        if (PC !== 11'd2047) begin
            bad++;
            $display("FAIL wrap_setup: got PC=%0d want 2047", PC);
        end
        runInstr(1'b0, 3'b000, 11'd5, 3, 0, 1'b0, 1'b0, 1'b0, e, j, cyc, ok);
        total++;
        if (PC !== 11'd0) begin
            bad++;
            $display("FAIL wrap_pc: got PC=%0d want 0", PC);
        end
        total++;
        if (cyc != 7 || !ok) begin
            bad++;
            $display("FAIL stall_fetch: got cycles=%0d ok=%b want 7 ok=1",
                     cyc, ok);
        end
    endtask

    task automatic test_random();
        bit e, j, ok;
        int cyc;
        int fd, ed;
        for (int i = 0; i < 60; i++) begin
            fd = $urandom_range(0, 3);
            ed = $urandom_range(0, 3);
            runInstr(1'($urandom), 3'($urandom), AW'($urandom), fd, ed,
                     1'($urandom), 1'($urandom), 1'($urandom),
                     e, j, cyc, ok);
            total++;
            if (PC !== mPc || j !== e) begin
                bad++;
                $display("FAIL rand_pc[%0d]: got PC=%0d jt=%b want PC=%0d jt=%b",
                         i, PC, j, mPc, e);
            end
            total++;
            if (ZF !== mZF || CF !== mCF) begin
                bad++;
                $display("FAIL rand_flags[%0d]: got ZF=%b CF=%b want ZF=%b CF=%b",
                         i, ZF, CF, mZF, mCF);
            end
            total++;
            if (cyc != 4 + fd + ed || !ok) begin
                bad++;
                $display("FAIL rand_timing[%0d]: got cycles=%0d ok=%b want %0d ok=1",
                         i, cyc, ok, 4 + fd + ed);
            end
        end
    endtask

    task automatic test_halt();
        bit j, ok, e;
        int cyc;
        logic [AW-1:0] hpc;
        doInstr(1'b1, 3'b000, 11'd9, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, j, cyc, ok);
        mZF = 1'b1;
        mCF = 1'b0;
        hpc = mPc;
        total++;
        if (halted !== 1'b1 || PC !== hpc || j !== 1'b0 || !ok) begin
            bad++;
            $display("FAIL halt_entry: got halted=%b PC=%0d jt=%b ok=%b want 1 %0d 0 1",
                     halted, PC, j, ok, hpc);
        end
        for (int i = 0; i < 10; i++) begin
            bus.fetchAck = 1'b1;
            bus.execDone = 1'b1;
            bus.jumpSignal = 1'b1;
            flagWe = 1'b1;
            aluZF = 1'b0;
            aluCF = 1'b1;
            @(negedge clk);
            total++;
            if (halted !== 1'b1 || bus.fetchReq !== 1'b0 || PC !== hpc
                || ZF !== 1'b1 || CF !== 1'b0 || jumpTaken !== 1'b0
                || bus.decodeStrobe !== 1'b0 || bus.execStart !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold[%0d]: got h=%b req=%b PC=%0d ZF=%b CF=%b want h=1 req=0 PC=%0d ZF=1 CF=0",
                         i, halted, bus.fetchReq, PC, ZF, CF, hpc);
            end
        end
        bus.fetchAck = 1'b0;
        bus.execDone = 1'b0;
        bus.jumpSignal = 1'b0;
        flagWe = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        total++;
        if (halted !== 1'b0 || PC !== 11'd0 || ZF !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: got halted=%b PC=%0d ZF=%b want 0 0 0",
                     halted, PC, ZF);
        end
        runInstr(1'b0, 3'd0, 11'd0, 0, 0, 1'b0, 1'b0, 1'b0, e, j, cyc, ok);
        total++;
        if (PC !== 11'd1 || !ok) begin
            bad++;
            $display("FAIL halt_restart: got PC=%0d ok=%b want PC=1 ok=1", PC, ok);
        end
    endtask

    task automatic test_reset_in_exec();
        bit e, j, ok;
        int cyc;
        int n;
        runInstr(1'b1, 3'b000, 11'd300, 0, 0, 1'b1, 1'b1, 1'b1, e, j, cyc, ok);
        n = 0;
        while (bus.fetchReq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.fetchAck = 1'b1;
        @(negedge clk);
        bus.fetchAck = 1'b0;
        @(negedge clk);
        bus.execDone = 1'b1;
        bus.jumpSignal = 1'b1;
        bus.IR = 3'b000;
        bus.Address = 11'd500;
        flagWe = 1'b1;
        aluZF = 1'b1;
        aluCF = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (PC !== 11'd0 || ZF !== 1'b0 || CF !== 1'b0
            || bus.fetchReq !== 1'b0 || jumpTaken !== 1'b0
            || halted !== 1'b0 || bus.execStart !== 1'b0 || n >= 50) begin
            bad++;
            $display("FAIL rst_exec: got PC=%0d ZF=%b CF=%b req=%b jt=%b want PC=0 flags 0 req=0 jt=0",
                     PC, ZF, CF, bus.fetchReq, jumpTaken);
        end
        bus.execDone = 1'b0;
        bus.jumpSignal = 1'b0;
        flagWe = 1'b0;
        rst = 1'b0;
        modelReset();
        runInstr(1'b0, 3'd0, 11'd0, 0, 0, 1'b0, 1'b0, 1'b0, e, j, cyc, ok);
        total++;
        if (PC !== 11'd1 || jumpTaken !== 1'b0 || !ok) begin
            bad++;
            $display("FAIL rst_exec_resume: got PC=%0d ok=%b want PC=1 ok=1",
                     PC, ok);
        end
    endtask

    initial begin
        bus.fetchAck = 1'b0;
        bus.execDone = 1'b0;
        bus.jumpSignal = 1'b0;
        bus.IR = 3'd0;
        bus.Address = '0;
        bus.halt = 1'b0;
        test_reset();
        test_sequential();
        test_jump_zf();
        test_cond_cf();
        test_wrap_stall();
        test_random();
        test_halt();
        test_reset_in_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
